clk_enable_gen: RTL and testbench
=================================

# clk_enable_gen

Multi-channel, run-time programmable clock-enable generator for the RISC-V demo top level; it replaces the fixed single-output clock divider. Each channel produces a one-cycle `tick` enable and a 50 %-duty square wave `sq` from the 100 MHz board clock. Each channel also has a halt and single-step mode, so the core can be clocked slowly, frozen, or stepped one cycle at a time from switches or a debug port. Downstream logic stays on `CLK` and qualifies its registers with `tick`; `sq` only drives LEDs or probes.

## Interface
- `CLOCK_FREQUENCY`, 100_000_000: input clock frequency in Hz.
- `CHANNELS`, 2: number of independent channels, at least 1.
- `DIV_WIDTH`, 24: width of the divisor and counter.
- `DEFAULT_FREQ`, 10: reset `sq` frequency in Hz. Reset divisor D0 = CLOCK_FREQUENCY/(2*DEFAULT_FREQ). D0 must fit in DIV_WIDTH and must be at least 1.
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `div_we`  in  1  divisor write strobe.
- `div_sel`  in  max(1,$clog2(CHANNELS))  channel to write. Values of CHANNELS or above are ignored.
- `div_data`  in  DIV_WIDTH  new divisor D.
- `mode`  in  2*CHANNELS  per channel, bits [2i+1:2i]: 00 RUN, 01 HALT, 10 STEP, 11 treated as HALT.
- `step`  in  CHANNELS  per-channel step request, level input, synchronous to `CLK`.
- `tick`  out  CHANNELS  registered one-cycle enable.
- `sq`  out  CHANNELS  registered square wave.

## Operation
Per-channel state:
- divisor register `div`, reset D0
- down-counter `cnt`, reset D0-1
- `sq`, reset 0
- `tick`, reset 0
- step-edge register `step_q`, reset 0

While `RST` is high, every output and register is held at its reset value. Reset asserted mid-operation clears everything immediately, with no wait for a clock edge.

Divisor write:
- On an edge with `div_we` high and a valid `div_sel`, `div[sel] <= div_data`.
- The new value takes effect at the next reload. The running period is never truncated.
- If a reload occurs on the same edge as the write, that reload uses the old `div`.
- Exception: if the old `div` was 0, `cnt` loads `div_data`-1 on that same edge.

RUN (mode 00):
- `cnt` != 0: `cnt` decrements and `tick` is 0.
- `cnt` == 0: `tick` <= 1, `sq` <= ~`sq`, and `cnt` <= `div`-1 (reload).
- `div` == 1: `tick` is high every cycle and `sq` toggles every cycle.
- `div` == 0: channel is disabled. `tick` = 0, `sq` holds, `cnt` holds.

HALT (mode 01 or 11):
- `cnt`, `sq` and `div` reload are frozen. `tick` = 0.
- Divisor writes are still accepted.

STEP (mode 10):
- `cnt` is frozen.
- A rising edge on `step[i]` (`step` = 1 and `step_q` = 0) sets `tick` <= 1 and `sq` <= ~`sq` on the next edge. `div` is ignored.
- Holding `step` high produces exactly one tick.
- `step_q` samples `step` every cycle in all modes. Entering STEP with `step` already high therefore produces no tick.

Mode changes:
- Sampled every edge.
- HALT/STEP to RUN resumes counting from the frozen `cnt`. There is no restart.
- RUN to HALT on a `cnt` == 0 edge: the halt wins, so no tick and no reload occur.

Channels are fully independent. The only shared resource is the write port.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- RUN: `tick` period = `div` cycles, pulse width exactly 1 cycle.
- RUN: `sq` period = 2*`div` cycles with 50 % duty. `sq` frequency = CLOCK_FREQUENCY/(2*`div`).
- After `RST` falls, the first `tick` is high in the D0-th cycle after the first rising edge. Counting that edge as 1, `tick` rises on edge D0.
- `sq` first goes to 1 on the same edge as the first `tick`.
- STEP latency: `step` seen high at edge N (with `step_q` = 0) gives `tick` high from edge N to edge N+1.
- Divisor change latency: at most old `div` cycles.

## Test plan
- Reset and defaults: CHANNELS=2, DEFAULT_FREQ=10,000,000 so D0=5. Release `RST` with mode RUN. Required: `tick` pulses on edges 5, 10, 15 after release, `sq` = 1,0,1 at those edges, all outputs 0 during reset.
- Reprogramming: channel 0 running with `div` = 5; write `div_data` = 3 at edge 2 of a period. Required: current period stays 5, the following periods are 3; channel 1 is unaffected.
- Boundary divisors: write 1, then check `tick` is high every cycle and `sq` toggles every cycle. Write 0, then check `tick` stays 0 and `sq` holds. Write 4, then check the first `tick` arrives 4 cycles after the write edge.
- Halt and resume: `div` = 6, switch to HALT at `cnt` = 2 and hold for 10 cycles. Required: no ticks, `sq` constant, the next tick arrives 3 cycles after returning to RUN. Also halt exactly on a `cnt` == 0 edge: no tick.
- Single step: mode STEP, `step` high for 7 cycles, then low for 3, then high for 1. Required: exactly two ticks, each 1 cycle wide, each one edge after a rising `step`, `sq` toggled twice. Entering STEP with `step` already high: no tick.
- Async reset mid-run: assert `RST` between edges while `tick` = 1. Required: `tick`, `sq` and `cnt` clear immediately, the divisor returns to D0, and the first-tick timing matches the reset scenario.

Source files
------------

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel programmable clock-enable generator.
// Each channel emits a one-cycle tick and a 50 % square wave, with
// run / halt / single-step control and a shared divisor write port.
module clk_enable_gen #(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned DIV_WIDTH       = 24,
  parameter int unsigned DEFAULT_FREQ    = 10,
  localparam int unsigned SEL_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    div_we,
  input  logic [SEL_W-1:0]        div_sel,
  input  logic [DIV_WIDTH-1:0]    div_data,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     step,
  output logic [CHANNELS-1:0]     tick,
  output logic [CHANNELS-1:0]     sq
);

  localparam int unsigned DIV_RESET = CLOCK_FREQUENCY / (2 * DEFAULT_FREQ);
  localparam logic [DIV_WIDTH-1:0] D0 = DIV_WIDTH'(DIV_RESET);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_HALT  = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_HALT2 = 2'b11
  } mode_e;

  // Write port decode shared by all channels; out-of-range selects are dropped.
  logic sel_ok_c;
  assign sel_ok_c = div_we && (32'(div_sel) < CHANNELS);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] div_q, div_n;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_n;
    logic                 sq_q, sq_n;
    logic                 tick_q, tick_n;
    logic                 step_q;
    logic                 wr_c;
    mode_e                mode_c;

    assign wr_c   = sel_ok_c && (32'(div_sel) == 32'(i));
    assign mode_c = mode_e'(mode[2*i +: 2]);

    // Next-state: counting, reload, halt freeze and step-edge toggling.
    always_comb begin
      div_n  = div_q;
      cnt_n  = cnt_q;
      sq_n   = sq_q;
      tick_n = 1'b0;
      if (wr_c) begin
        div_n = div_data;
      end
      unique case (mode_c)
        MODE_RUN: begin
          if (div_q != '0) begin
            if (cnt_q == '0) begin
              tick_n = 1'b1;
              sq_n   = ~sq_q;
              cnt_n  = div_q - DIV_WIDTH'(1);
            end else begin
              cnt_n = cnt_q - DIV_WIDTH'(1);
            end
          end
        end
        MODE_STEP: begin
          if (step[i] && !step_q) begin
            tick_n = 1'b1;
            sq_n   = ~sq_q;
          end
        end
        default: begin
        end
      endcase
      // A disabled channel has no pending period, so a new divisor restarts it at once.
      if (wr_c && (div_q == '0) && (div_data != '0)) begin
        cnt_n = div_data - DIV_WIDTH'(1);
      end
    end

    // Channel state registers with asynchronous reset to the default rate.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        div_q  <= D0;
        cnt_q  <= D0 - DIV_WIDTH'(1);
        sq_q   <= 1'b0;
        tick_q <= 1'b0;
        step_q <= 1'b0;
      end else begin
        div_q  <= div_n;
        cnt_q  <= cnt_n;
        sq_q   <= sq_n;
        tick_q <= tick_n;
        step_q <= step[i];
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: two channels, D0 = 5.
module tb_clk_enable_gen;

  localparam int unsigned CH  = 2;
  localparam int unsigned DW  = 24;
  localparam int unsigned SW  = 1;

  logic            CLK;
  logic            RST;
  logic            div_we;
  logic [SW-1:0]   div_sel;
  logic [DW-1:0]   div_data;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   step;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   sq;

  int errors = 0;
  int checks = 0;
  logic [CH-1:0] exp_sq;

  clk_enable_gen #(
    .CLOCK_FREQUENCY(100_000_000),
    .CHANNELS(CH),
    .DIV_WIDTH(DW),
    .DEFAULT_FREQ(10_000_000)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .div_we(div_we),
    .div_sel(div_sel),
    .div_data(div_data),
    .mode(mode),
    .step(step),
    .tick(tick),
    .sq(sq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then compare tick and sq against the expected pattern.
  task automatic step_chk(input logic [CH-1:0] et, input int e);
    @(posedge CLK);
    #1;
    exp_sq = exp_sq ^ et;
    check($sformatf("tick e%0d", e), 32'(tick), 32'(et));
    check($sformatf("sq e%0d", e), 32'(sq), 32'(exp_sq));
  endtask

  // Channel 0 expected ticks after reset release, worked out by hand.
  function automatic logic exp_t0(input int e);
    if (e <= 15) return (e % 5) == 0;
    if (e <= 30) return (e == 20) || (e == 23) || (e == 26) || (e == 29);
    if (e <= 51) return ((e >= 32) && (e <= 37)) || (e == 47) || (e == 51);
    if (e <= 85) return (e == 55) || (e == 71) || (e == 81);
    return (e == 87) || (e == 97) || (e == 102);
  endfunction

  initial begin
    RST      = 1'b1;
    div_we   = 1'b0;
    div_sel  = '0;
    div_data = '0;
    mode     = '0;
    step     = '0;
    exp_sq   = '0;

    // Outputs low while reset is held.
    for (int k = 0; k < 3; k++) step_chk(2'b00, -1);
    RST = 1'b0;

    for (int e = 1; e <= 110; e++) begin
      step_chk({logic'((e % 5) == 0), exp_t0(e)}, e);
      case (e)
        16:  begin div_we = 1'b1; div_sel = 1'b0; div_data = 24'd3; end
        30:  begin div_we = 1'b1; div_sel = 1'b0; div_data = 24'd1; end
        36:  begin div_we = 1'b1; div_sel = 1'b0; div_data = 24'd0; end
        42:  begin div_we = 1'b1; div_sel = 1'b0; div_data = 24'd4; end
        51:  begin div_we = 1'b1; div_sel = 1'b0; div_data = 24'd6; end
        17, 31, 37, 43, 52: div_we = 1'b0;
        58:  mode[1:0] = 2'b01;
        68:  mode[1:0] = 2'b00;
        76:  mode[1:0] = 2'b01;
        80:  mode[1:0] = 2'b00;
        85:  mode[1:0] = 2'b10;
        86:  step[0] = 1'b1;
        93:  step[0] = 1'b0;
        96:  step[0] = 1'b1;
        97:  step[0] = 1'b0;
        100: begin mode[1:0] = 2'b00; step[0] = 1'b1; end
        102: mode[1:0] = 2'b10;
        106: begin mode[1:0] = 2'b00; step[0] = 1'b0; end
        default: ;
      endcase
    end

    // Asynchronous reset between edges while channel 1 is ticking.
    RST = 1'b1;
    #2;
    check("async tick", 32'(tick), 32'h0);
    check("async sq", 32'(sq), 32'h0);
    exp_sq = '0;
    #3;
    RST = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step_chk({2{logic'((e % 5) == 0)}}, 200 + e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
